// File: rtl/ifft_module.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_module
//  Description : Sequential radix-2 DIT inverse FFT. Frequency bins are
//                loaded serially into bit-reversed RAM positions. One
//                butterfly is computed in place per clock, with a 1/2 scale
//                per stage. Time samples are then streamed out in natural
//                order under valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifft_module #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_POINTS = 8,
    parameter int TW_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_LOG2N   = $clog2(FFT_POINTS);
    localparam int c_HALF    = FFT_POINTS / 2;
    localparam int c_SW      = 2;                            // stage index width (up to 4 stages)
    localparam int c_XW      = DATA_WIDTH + 2;               // butterfly add/sub width
    localparam int c_FW      = DATA_WIDTH + TW_WIDTH + 1;    // full product-sum width
    localparam int c_ROM_SH  = 4 - c_LOG2N;                  // scales twiddle index onto 16-point table

    localparam logic [c_LOG2N-1:0] c_LAST_IDX   = c_LOG2N'(FFT_POINTS - 1);
    localparam logic [c_LOG2N-1:0] c_LAST_BFLY  = c_LOG2N'(c_HALF - 1);
    localparam logic [c_LOG2N-1:0] c_ONE        = c_LOG2N'(1);
    localparam logic [c_SW-1:0]    c_LAST_STAGE = c_SW'(c_LOG2N - 1);

    // Only 8- and 16-point transforms have twiddles in the table below
    if (!(FFT_POINTS == 8 || FFT_POINTS == 16)) begin : g_bad_points
        $error("ifft_module: FFT_POINTS must be 8 or 16");
    end

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [c_LOG2N-1:0]       r_cnt;      // load index / butterfly index / output index
    logic [c_SW-1:0]          r_stage;
    logic                     r_done;

    // Sample RAM: register array so a pair can be read and both results
    // written back in the same cycle
    logic signed [DATA_WIDTH-1:0] r_mem_re [FFT_POINTS];
    logic signed [DATA_WIDTH-1:0] r_mem_im [FFT_POINTS];

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [c_LOG2N-1:0] f_bitrev(input logic [c_LOG2N-1:0] v);
        logic [c_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < c_LOG2N; i++) begin
            r[i] = v[c_LOG2N-1-i];
        end
        return r;
    endfunction

    // 16-point twiddle table, cos(2*pi*j/16) in Q2.14; 8-point uses even entries
    function automatic logic signed [TW_WIDTH-1:0] f_tw_cos(input logic [3:0] j);
        logic signed [TW_WIDTH-1:0] v;
        case (j)
            4'd0:    v = TW_WIDTH'(16384);
            4'd1:    v = TW_WIDTH'(15137);
            4'd2:    v = TW_WIDTH'(11585);
            4'd3:    v = TW_WIDTH'(6270);
            4'd4:    v = TW_WIDTH'(0);
            4'd5:    v = TW_WIDTH'(-6270);
            4'd6:    v = TW_WIDTH'(-11585);
            4'd7:    v = TW_WIDTH'(-15137);
            default: v = TW_WIDTH'(0);
        endcase
        return v;
    endfunction

    // Positive-angle sine: the inverse transform rotates counter-clockwise
    function automatic logic signed [TW_WIDTH-1:0] f_tw_sin(input logic [3:0] j);
        logic signed [TW_WIDTH-1:0] v;
        case (j)
            4'd0:    v = TW_WIDTH'(0);
            4'd1:    v = TW_WIDTH'(6270);
            4'd2:    v = TW_WIDTH'(11585);
            4'd3:    v = TW_WIDTH'(15137);
            4'd4:    v = TW_WIDTH'(16384);
            4'd5:    v = TW_WIDTH'(15137);
            4'd6:    v = TW_WIDTH'(11585);
            4'd7:    v = TW_WIDTH'(6270);
            default: v = TW_WIDTH'(0);
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Transfer qualifiers
    // ------------------------------------------------------------------------
    logic w_in_xfer;
    logic w_out_xfer;
    assign w_in_xfer  = in_valid  & (r_state == S_LOAD);
    assign w_out_xfer = out_ready & (r_state == S_UNLOAD);

    // ------------------------------------------------------------------------
    // Butterfly addressing: butterfly b of stage s splits into group g and
    // offset k (span h = 2^s); A = g*2h + k, B = A + h, twiddle m = k*N/(2h)
    // ------------------------------------------------------------------------
    logic [c_LOG2N-1:0] w_span;
    logic [c_LOG2N-1:0] w_mask;
    logic [c_LOG2N-1:0] w_k;
    logic [c_LOG2N-1:0] w_idx_a;
    logic [c_LOG2N-1:0] w_idx_b;
    logic [c_LOG2N-1:0] w_tw_idx;
    logic [3:0]         w_rom_idx;

    assign w_span    = c_ONE << r_stage;
    assign w_mask    = w_span - c_ONE;
    assign w_k       = r_cnt & w_mask;
    assign w_idx_a   = ((r_cnt & ~w_mask) << 1) | w_k;
    assign w_idx_b   = w_idx_a | w_span;
    assign w_tw_idx  = w_k << (c_LAST_STAGE - r_stage);
    assign w_rom_idx = 4'(w_tw_idx) << c_ROM_SH;

    // ------------------------------------------------------------------------
    // Butterfly datapath: t = B*W, A' = (A+t)/2, B' = (A-t)/2
    // ------------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [TW_WIDTH-1:0]   w_wr, w_wi;
    logic signed [c_FW-1:0]       w_b_re_x, w_b_im_x, w_wr_x, w_wi_x;
    logic signed [c_FW-1:0]       w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [c_XW-1:0]       w_t_re, w_t_im, w_a_re_x, w_a_im_x;
    logic signed [DATA_WIDTH-1:0] w_new_a_re, w_new_a_im, w_new_b_re, w_new_b_im;

    assign w_a_re = r_mem_re[w_idx_a];
    assign w_a_im = r_mem_im[w_idx_a];
    assign w_b_re = r_mem_re[w_idx_b];
    assign w_b_im = r_mem_im[w_idx_b];
    assign w_wr   = f_tw_cos(w_rom_idx);
    assign w_wi   = f_tw_sin(w_rom_idx);

    assign w_b_re_x = {{(c_FW-DATA_WIDTH){w_b_re[DATA_WIDTH-1]}}, w_b_re};
    assign w_b_im_x = {{(c_FW-DATA_WIDTH){w_b_im[DATA_WIDTH-1]}}, w_b_im};
    assign w_wr_x   = {{(c_FW-TW_WIDTH){w_wr[TW_WIDTH-1]}}, w_wr};
    assign w_wi_x   = {{(c_FW-TW_WIDTH){w_wi[TW_WIDTH-1]}}, w_wi};

    assign w_p_rr = w_b_re_x * w_wr_x;
    assign w_p_ii = w_b_im_x * w_wi_x;
    assign w_p_ri = w_b_re_x * w_wi_x;
    assign w_p_ir = w_b_im_x * w_wr_x;

    // Twiddles carry 14 fractional bits; truncate them away after the sum
    assign w_t_re = c_XW'((w_p_rr - w_p_ii) >>> 14);
    assign w_t_im = c_XW'((w_p_ri + w_p_ir) >>> 14);

    assign w_a_re_x = {{2{w_a_re[DATA_WIDTH-1]}}, w_a_re};
    assign w_a_im_x = {{2{w_a_im[DATA_WIDTH-1]}}, w_a_im};

    assign w_new_a_re = DATA_WIDTH'((w_a_re_x + w_t_re) >>> 1);
    assign w_new_a_im = DATA_WIDTH'((w_a_im_x + w_t_im) >>> 1);
    assign w_new_b_re = DATA_WIDTH'((w_a_re_x - w_t_re) >>> 1);
    assign w_new_b_im = DATA_WIDTH'((w_a_im_x - w_t_im) >>> 1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == c_LAST_IDX)) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if ((r_stage == c_LAST_STAGE) && (r_cnt == c_LAST_BFLY)) begin
                    w_state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && (r_cnt == c_LAST_IDX)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared index counter and stage counter; every phase ends with them at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_stage <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_stage <= '0;
                end
                S_LOAD: begin
                    if (w_in_xfer) begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_COMPUTE: begin
                    if (r_cnt == c_LAST_BFLY) begin
                        r_cnt   <= '0;
                        r_stage <= (r_stage == c_LAST_STAGE) ? '0 : r_stage + c_SW'(1);
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_UNLOAD: begin
                    if (w_out_xfer) begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_stage <= '0;
                end
            endcase
        end
    end

    // Sample RAM writes: bit-reversed load, then in-place butterfly results
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_mem_re[f_bitrev(r_cnt)] <= in_re;
            r_mem_im[f_bitrev(r_cnt)] <= in_im;
        end else if (r_state == S_COMPUTE) begin
            r_mem_re[w_idx_a] <= w_new_a_re;
            r_mem_im[w_idx_a] <= w_new_a_im;
            r_mem_re[w_idx_b] <= w_new_b_re;
            r_mem_im[w_idx_b] <= w_new_b_im;
        end
    end

    // Completion pulse, raised the cycle after the final output transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_out_xfer && (r_cnt == c_LAST_IDX);
        end
    end

    // Output data reads straight from RAM so it stays stable during stalls
    assign out_re   = (r_state == S_UNLOAD) ? r_mem_re[r_cnt] : '0;
    assign out_im   = (r_state == S_UNLOAD) ? r_mem_im[r_cnt] : '0;
    assign out_last = out_valid & (r_cnt == c_LAST_IDX);
    assign done     = r_done;

endmodule
`default_nettype wire
